mem_stage: RTL and testbench

Memory-access stage of the pipelined MIPS core, directly downstream of the EX/MEM pipeline latch. It issues data-cache requests for loads, stores, LL and SC, and holds the pipeline with `mem_stall` until the cache answers. It also maintains the LL/SC link register and the sticky halt. Its registered writeback outputs replace a separate MEM/WB latch and feed the register file write port and forwarding unit.

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the pipelined MIPS core. Issues data
//               cache requests for LW/SW/LL/SC, stalls the pipeline until the
//               cache answers, keeps the LL/SC link register and the sticky
//               halt. Registered writeback outputs serve as the MEM/WB latch.
// Ports       : CLK, nRST (async, active-low)
//               ex_*      : instruction held in the EX/MEM latch
//               dhit, dmemload          : cache response
//               snoop_inv, snoop_addr   : coherence invalidate
//               dmemREN/WEN/addr/store  : cache request
//               mem_stall               : freeze EX/MEM and upstream
//               wb_*                    : registered writeback
//               halt_o                  : sticky halt
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ex_valid,
   input  logic        ex_dREN,
   input  logic        ex_dWEN,
   input  logic        ex_ll,
   input  logic        ex_sc,
   input  logic        ex_MemToReg,
   input  logic        ex_RegWr,
   input  logic        ex_halt,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_alu,
   input  logic [31:0] ex_wdat,
   input  logic [4:0]  ex_wsel,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   input  logic        snoop_inv,
   input  logic [31:0] snoop_addr,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic        mem_stall,
   output logic        wb_valid,
   output logic        wb_RegWr,
   output logic [4:0]  wb_wsel,
   output logic [31:0] wb_wdat,
   output logic        halt_o
);

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        link_valid_q, link_valid_d;
   logic [29:0] link_addr_q, link_addr_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_regwr_q, wb_regwr_d;
   logic [4:0]  wb_wsel_q, wb_wsel_d;
   word_t       wb_wdat_q, wb_wdat_d;

   logic        snoop_hit;
   logic        sc_link_ok;
   logic        mem_op;
   logic        ren, wen, stall;
   logic        complete;
   logic        issued;
   logic        snoop_lsb_unused;

   // Byte offset of the snoop address plays no part in word-granular linking.
   assign snoop_lsb_unused = ^snoop_addr[1:0];

   assign snoop_hit  = snoop_inv & link_valid_q & (snoop_addr[31:2] == link_addr_q);
   // A snoop landing in the same cycle the SC is evaluated kills the SC.
   assign sc_link_ok = link_valid_q & (ex_addr[31:2] == link_addr_q) & ~snoop_hit;
   // A failing SC is not a memory op: it completes at once with no request.
   assign mem_op     = ex_valid & (ex_dREN | ex_dWEN) & ~(ex_sc & ~sc_link_ok);

   // ------------------------------------------------------------------------
   // Control FSM: next state, cache request, stall and completion strobe
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ren      = 1'b0;
      wen      = 1'b0;
      stall    = 1'b0;
      complete = 1'b0;
      issued   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (ex_halt) begin
                  state_d = HALTED;
               end else if (mem_op) begin
                  ren    = ex_dREN;
                  wen    = ex_dWEN;
                  issued = 1'b1;
                  if (dhit) begin
                     complete = 1'b1;
                  end else begin
                     stall   = 1'b1;
                     state_d = WAIT;
                  end
               end else begin
                  complete = 1'b1;
               end
            end
         end
         WAIT: begin
            // The SC decision was taken on entry; later snoops do not abort it.
            if (!ex_valid) begin
               state_d = IDLE;
            end else begin
               ren    = ex_dREN;
               wen    = ex_dWEN;
               issued = 1'b1;
               if (dhit) begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         HALTED: begin
            stall = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Writeback data and link register
   // ------------------------------------------------------------------------
   always_comb begin
      wb_valid_d = complete;
      wb_regwr_d = complete & ex_RegWr;
      wb_wsel_d  = complete ? ex_wsel : 5'd0;
      wb_wdat_d  = '0;
      if (complete) begin
         if (ex_MemToReg) begin
            wb_wdat_d = dmemload;
         end else if (ex_sc) begin
            // SC reports success only if it actually reached the cache.
            wb_wdat_d = {31'd0, issued};
         end else begin
            wb_wdat_d = ex_alu;
         end
      end
   end

   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      // LL completion wins over a simultaneous snoop.
      if (complete & ex_ll) begin
         link_valid_d = 1'b1;
         link_addr_d  = ex_addr[31:2];
      end else if (complete & (ex_dWEN | ex_sc)) begin
         link_valid_d = 1'b0;
      end else if (snoop_hit) begin
         link_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         wb_valid_q   <= 1'b0;
         wb_regwr_q   <= 1'b0;
         wb_wsel_q    <= '0;
         wb_wdat_q    <= '0;
      end else begin
         state_q      <= state_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
         wb_valid_q   <= wb_valid_d;
         wb_regwr_q   <= wb_regwr_d;
         wb_wsel_q    <= wb_wsel_d;
         wb_wdat_q    <= wb_wdat_d;
      end
   end

   // Combinational outputs are forced low while reset is held so a request
   // in flight is dropped immediately.
   assign dmemREN   = nRST & ren;
   assign dmemWEN   = nRST & wen;
   assign mem_stall = nRST & stall;
   assign dmemaddr  = {ex_addr[31:2], 2'b00};
   assign dmemstore = ex_wdat;

   assign wb_valid  = wb_valid_q;
   assign wb_RegWr  = wb_regwr_q;
   assign wb_wsel   = wb_wsel_q;
   assign wb_wdat   = wb_wdat_q;
   assign halt_o    = (state_q == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed vector table,
//               hand-written multi-cycle sequences and randomized
//               instructions checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam int K_BUB  = 0;
   localparam int K_ALU  = 1;
   localparam int K_LW   = 2;
   localparam int K_SW   = 3;
   localparam int K_LL   = 4;
   localparam int K_SC   = 5;
   localparam int K_HALT = 6;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc;
   logic        ex_MemToReg, ex_RegWr, ex_halt;
   logic [31:0] ex_addr, ex_alu, ex_wdat;
   logic [4:0]  ex_wsel;
   logic        dhit;
   logic [31:0] dmemload;
   logic        snoop_inv;
   logic [31:0] snoop_addr;
   logic        dmemREN, dmemWEN, mem_stall;
   logic [31:0] dmemaddr, dmemstore;
   logic        wb_valid, wb_RegWr;
   logic [4:0]  wb_wsel;
   logic [31:0] wb_wdat;
   logic        halt_o;

   int total = 0;
   int bad   = 0;

   mem_stage dut (
      .CLK(CLK), .nRST(nRST),
      .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
      .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_MemToReg(ex_MemToReg),
      .ex_RegWr(ex_RegWr), .ex_halt(ex_halt), .ex_addr(ex_addr),
      .ex_alu(ex_alu), .ex_wdat(ex_wdat), .ex_wsel(ex_wsel),
      .dhit(dhit), .dmemload(dmemload),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall),
      .wb_valid(wb_valid), .wb_RegWr(wb_RegWr), .wb_wsel(wb_wsel),
      .wb_wdat(wb_wdat), .halt_o(halt_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int kind, input logic [31:0] addr, input logic [31:0] alu,
                        input logic [31:0] wdat, input logic [4:0] wsel);
      ex_valid    = (kind != K_BUB);
      ex_dREN     = (kind == K_LW) || (kind == K_LL);
      ex_dWEN     = (kind == K_SW) || (kind == K_SC);
      ex_ll       = (kind == K_LL);
      ex_sc       = (kind == K_SC);
      ex_MemToReg = ex_dREN;
      ex_RegWr    = (kind == K_ALU) || (kind == K_LW) || (kind == K_LL) || (kind == K_SC);
      ex_halt     = (kind == K_HALT);
      if (kind == K_BUB) begin
         // Junk control bits on a bubble must never reach the cache or regfile.
         ex_dREN  = 1'($urandom_range(0, 1));
         ex_dWEN  = 1'($urandom_range(0, 1));
         ex_RegWr = 1'b1;
      end
      ex_addr = addr;
      ex_alu  = alu;
      ex_wdat = wdat;
      ex_wsel = wsel;
   endtask

   task automatic setio(input logic hit, input logic [31:0] load,
                        input logic sinv, input logic [31:0] saddr);
      dhit       = hit;
      dmemload   = load;
      snoop_inv  = sinv;
      snoop_addr = saddr;
   endtask

   // Called just after a rising edge; checks the combinational outputs at the
   // falling edge and the writeback registers just after the next rising edge.
   task automatic do_cycle(input string tag, input logic er, input logic ew,
                           input logic est, input logic ewv, input logic ewr,
                           input logic [4:0] ews, input logic [31:0] ewd);
      logic [31:0] exp_addr;
      exp_addr = {ex_addr[31:2], 2'b00};
      @(negedge CLK);
      chk({tag, ".dmemREN"}, dmemREN, er);
      chk({tag, ".dmemWEN"}, dmemWEN, ew);
      chk({tag, ".mem_stall"}, mem_stall, est);
      if (er || ew) chk({tag, ".dmemaddr"}, dmemaddr, exp_addr);
      if (ew) chk({tag, ".dmemstore"}, dmemstore, ex_wdat);
      @(posedge CLK);
      #1;
      chk({tag, ".wb_valid"}, wb_valid, ewv);
      chk({tag, ".wb_RegWr"}, wb_RegWr, ewr);
      if (ewv) begin
         chk({tag, ".wb_wsel"}, wb_wsel, ews);
         chk({tag, ".wb_wdat"}, wb_wdat, ewd);
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #1;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] alu;
      logic [31:0] wdat;
      logic [4:0]  wsel;
      logic        hit;
      logic [31:0] load;
      logic        er, ew, est, ewv, ewr;
      logic [31:0] ewd;
   } vec_t;

   vec_t tbl[10];

   // Random-phase variables and model state
   logic [31:0] pool [3];
   int          kind, lat;
   logic [31:0] r_addr, r_alu, r_wdat, r_ld, r_saddr, r_ewd;
   logic [4:0]  r_wsel;
   logic        r_sinv, r_issue, r_last, r_hit;
   logic        m_lv;
   logic [29:0] m_la;

   initial begin
      // ---------------- reset state ----------------
      nRST = 1'b0;
      drive(K_LW, 32'h104, 32'h0, 32'h0, 5'd1);
      setio(1'b1, 32'h1, 1'b0, 32'h0);
      #1;
      chk("rst.dmemREN", dmemREN, 1'b0);
      chk("rst.dmemWEN", dmemWEN, 1'b0);
      chk("rst.mem_stall", mem_stall, 1'b0);
      chk("rst.wb_valid", wb_valid, 1'b0);
      chk("rst.wb_RegWr", wb_RegWr, 1'b0);
      chk("rst.wb_wsel", wb_wsel, 5'd0);
      chk("rst.wb_wdat", wb_wdat, 32'd0);
      chk("rst.halt_o", halt_o, 1'b0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // ---------------- directed vector table ----------------
      //           kind   addr        alu         wdat        wsel hit load         er ew st wv wr  wdat
      tbl[0] = '{K_LW,  32'h104,  32'h0,      32'h0,      5'd3, 1, 32'hDEADBEEF, 1, 0, 0, 1, 1, 32'hDEADBEEF};
      tbl[1] = '{K_ALU, 32'h0,    32'h7,      32'h0,      5'd5, 0, 32'h0,        0, 0, 0, 1, 1, 32'h7};
      tbl[2] = '{K_SW,  32'h208,  32'h55,     32'hCAFE,   5'd0, 1, 32'h0,        0, 1, 0, 1, 0, 32'h55};
      tbl[3] = '{K_BUB, 32'h10,   32'h0,      32'h0,      5'd0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0};
      tbl[4] = '{K_SC,  32'h40,   32'h0,      32'h9,      5'd4, 1, 32'h0,        0, 0, 0, 1, 1, 32'h0};
      tbl[5] = '{K_LL,  32'h40,   32'h0,      32'h0,      5'd2, 1, 32'h1111,     1, 0, 0, 1, 1, 32'h1111};
      tbl[6] = '{K_SC,  32'h42,   32'h0,      32'h9,      5'd4, 1, 32'h0,        0, 1, 0, 1, 1, 32'h1};
      tbl[7] = '{K_SC,  32'h40,   32'h0,      32'h9,      5'd4, 1, 32'h0,        0, 0, 0, 1, 1, 32'h0};
      tbl[8] = '{K_LW,  32'h7,    32'h0,      32'h0,      5'd9, 1, 32'hA5,       1, 0, 0, 1, 1, 32'hA5};
      tbl[9] = '{K_ALU, 32'h0,    32'h99,     32'h0,      5'd31,1, 32'hFFFF,     0, 0, 0, 1, 1, 32'h99};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].kind, tbl[i].addr, tbl[i].alu, tbl[i].wdat, tbl[i].wsel);
         setio(tbl[i].hit, tbl[i].load, 1'b0, 32'h0);
         do_cycle($sformatf("vec%0d", i), tbl[i].er, tbl[i].ew, tbl[i].est,
                  tbl[i].ewv, tbl[i].ewr, tbl[i].wsel, tbl[i].ewd);
      end

      // ---------------- SW miss, dhit on the fourth cycle ----------------
      drive(K_SW, 32'h203, 32'h77, 32'h1234, 5'd0);
      for (int c = 0; c < 4; c++) begin
         setio(c == 3, 32'h0, 1'b0, 32'h0);
         do_cycle($sformatf("swmiss%0d", c), 1'b0, 1'b1, c != 3, c == 3, 1'b0, 5'd0, 32'h77);
      end

      // ---------------- LW miss by one cycle ----------------
      drive(K_LW, 32'h10, 32'h0, 32'h0, 5'd6);
      setio(1'b0, 32'hBAD, 1'b0, 32'h0);
      do_cycle("lwmiss0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0);
      setio(1'b1, 32'h600D, 1'b0, 32'h0);
      do_cycle("lwmiss1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h600D);

      // ---------------- LL, snoop on a later cycle, SC fails ----------------
      drive(K_LL, 32'h40, 32'h0, 32'h0, 5'd2);
      setio(1'b1, 32'h5, 1'b0, 32'h0);
      do_cycle("snp.ll", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h5);
      drive(K_ALU, 32'h0, 32'h3, 32'h0, 5'd1);
      setio(1'b0, 32'h0, 1'b1, 32'h43);
      do_cycle("snp.alu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h3);
      drive(K_SC, 32'h40, 32'h0, 32'h8, 5'd3);
      setio(1'b1, 32'h0, 1'b0, 32'h0);
      do_cycle("snp.sc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0);

      // ---------------- snoop in the same cycle as the SC ----------------
      drive(K_LL, 32'h80, 32'h0, 32'h0, 5'd2);
      setio(1'b1, 32'h6, 1'b0, 32'h0);
      do_cycle("same.ll", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h6);
      drive(K_SC, 32'h80, 32'h0, 32'h8, 5'd3);
      setio(1'b1, 32'h0, 1'b1, 32'h81);
      do_cycle("same.sc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0);

      // ---------------- snoop in the same cycle as the LL is ignored ----------------
      drive(K_LL, 32'h80, 32'h0, 32'h0, 5'd2);
      setio(1'b1, 32'h7, 1'b1, 32'h80);
      do_cycle("llsnp.ll", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h7);
      drive(K_SC, 32'h80, 32'h0, 32'h8, 5'd3);
      setio(1'b1, 32'h0, 1'b0, 32'h0);
      do_cycle("llsnp.sc", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h1);

      // ---------------- snoop while the SC waits does not abort it ----------------
      drive(K_LL, 32'hC0, 32'h0, 32'h0, 5'd2);
      setio(1'b1, 32'h8, 1'b0, 32'h0);
      do_cycle("wsnp.ll", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h8);
      drive(K_SC, 32'hC0, 32'h0, 32'hAB, 5'd3);
      setio(1'b0, 32'h0, 1'b0, 32'h0);
      do_cycle("wsnp.sc0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      setio(1'b0, 32'h0, 1'b1, 32'hC0);
      do_cycle("wsnp.sc1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      setio(1'b1, 32'h0, 1'b0, 32'h0);
      do_cycle("wsnp.sc2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h1);
      setio(1'b1, 32'h0, 1'b0, 32'h0);
      do_cycle("wsnp.sc3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0);

      // ---------------- reset in the middle of a wait ----------------
      drive(K_SW, 32'h300, 32'h0, 32'h99, 5'd0);
      setio(1'b0, 32'h0, 1'b0, 32'h0);
      do_cycle("rstw.sw", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      #2;
      nRST = 1'b0;
      #1;
      chk("rstw.dmemWEN", dmemWEN, 1'b0);
      chk("rstw.mem_stall", mem_stall, 1'b0);
      chk("rstw.wb_valid", wb_valid, 1'b0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive(K_ALU, 32'h0, 32'h42, 32'h0, 5'd7);
      setio(1'b0, 32'h0, 1'b0, 32'h0);
      do_cycle("rstw.alu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h42);

      // ---------------- randomized instructions vs. model ----------------
      do_reset();
      m_lv = 1'b0;
      m_la = '0;
      pool[0] = 32'h0000_1040;
      pool[1] = 32'h0000_1044;
      pool[2] = 32'h0000_2080;
      for (int n = 0; n < 300; n++) begin
         kind    = $urandom_range(0, 5);
         r_addr  = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
         r_alu   = $urandom;
         r_wdat  = $urandom;
         r_wsel  = 5'($urandom_range(0, 31));
         r_sinv  = ($urandom_range(0, 3) == 0);
         r_saddr = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
         if (kind == K_SC)
            r_issue = m_lv && (r_addr[31:2] == m_la) && !(r_sinv && (r_saddr[31:2] == m_la));
         else
            r_issue = (kind == K_LW) || (kind == K_SW) || (kind == K_LL);
         lat = r_issue ? $urandom_range(0, 3) : 0;
         drive(kind, r_addr, r_alu, r_wdat, r_wsel);
         for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
               r_sinv  = ($urandom_range(0, 3) == 0);
               r_saddr = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
            end
            r_ld   = $urandom;
            r_last = (c == lat);
            r_hit  = r_issue ? r_last : 1'($urandom_range(0, 1));
            setio(r_hit, r_ld, r_sinv, r_saddr);
            if ((kind == K_LW) || (kind == K_LL)) r_ewd = r_ld;
            else if (kind == K_SC)                r_ewd = {31'd0, r_issue};
            else                                  r_ewd = r_alu;
            do_cycle($sformatf("rnd%0d.%0d", n, c),
                     r_issue && ((kind == K_LW) || (kind == K_LL)),
                     r_issue && ((kind == K_SW) || (kind == K_SC)),
                     r_issue && !r_last,
                     r_last && (kind != K_BUB),
                     r_last && ((kind == K_ALU) || (kind == K_LW) || (kind == K_LL) || (kind == K_SC)),
                     r_wsel, r_ewd);
            if (r_last && (kind == K_LL)) begin
               m_lv = 1'b1;
               m_la = r_addr[31:2];
            end else if (r_last && ((kind == K_SW) || (kind == K_SC))) begin
               m_lv = 1'b0;
            end else if (r_sinv && m_lv && (r_saddr[31:2] == m_la)) begin
               m_lv = 1'b0;
            end
         end
      end

      // ---------------- halt, then nothing issues, then reset ----------------
      drive(K_HALT, 32'h0, 32'h0, 32'h0, 5'd0);
      setio(1'b0, 32'h0, 1'b0, 32'h0);
      do_cycle("halt.ins", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("halt.halt_o", halt_o, 1'b1);
      drive(K_LW, 32'h104, 32'h0, 32'h0, 5'd3);
      setio(1'b1, 32'h1234, 1'b0, 32'h0);
      do_cycle("halt.lw", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      chk("halt.halt_o2", halt_o, 1'b1);
      #2;
      nRST = 1'b0;
      #1;
      chk("hrst.dmemREN", dmemREN, 1'b0);
      chk("hrst.mem_stall", mem_stall, 1'b0);
      chk("hrst.wb_valid", wb_valid, 1'b0);
      chk("hrst.wb_wdat", wb_wdat, 32'd0);
      chk("hrst.halt_o", halt_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
